// File: rtl/shifter_operand_pipe.sv
// shifter_operand_pipe: pipelined ARM shifter operand (n) and carry-out.
// Ports: clk, reset (async, active-high); in_valid/in_ready with rm,
// rs_amt, imm, mode, c_in; out_valid/out_ready with n, c_out.
module shifter_operand_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rm,
  input  logic [7:0]       rs_amt,
  input  logic [11:0]      imm,
  input  logic [1:0]       mode,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] n,
  output logic             c_out
);
  localparam int W  = WIDTH;
  localparam int LW = $clog2(WIDTH);
  localparam logic [8:0] WV = 9'(WIDTH);

  typedef logic [LW-1:0] sh_t;

  // Every operation becomes: rotate v right by r, keep bits where m
  // is set, fill the rest with f. c is resolved up front.
  typedef struct packed {
    logic [W-1:0] v;
    sh_t          r;
    logic [W-1:0] m;
    logic         f;
    logic         c;
  } bun_t;

  logic              adv;
  logic [STAGES-1:0] vld_q;
  logic [STAGES-1:0] vld_d;
  logic [W-1:0]      n_q;
  logic              c_q;

  logic [1:0]   ty;
  logic [7:0]   amt;
  logic [7:0]   rot8;
  sh_t          irot;
  sh_t          al;
  sh_t          ai;
  sh_t          ni;
  logic         lt;
  logic         eq;
  logic [W-1:0] i8;
  bun_t         dec;

  always_comb begin
    ty   = imm[6:5];
    rot8 = {3'b000, imm[11:8], 1'b0};
    irot = rot8[LW-1:0];
    i8   = W'(imm[7:0]);
    // LSR/ASR #0 encode a shift by the full width
    if (mode == 2'b01) begin
      if (imm[11:7] == 5'd0 && ty inside {2'b01, 2'b10})
        amt = 8'(WIDTH);
      else
        amt = {3'b000, imm[11:7]};
    end else begin
      amt = rs_amt;
    end
    al = amt[LW-1:0];
    ai = al - sh_t'(1);
    ni = -al;
    lt = {1'b0, amt} < WV;
    eq = {1'b0, amt} == WV;

    dec   = '0;
    dec.v = rm;
    dec.m = {W{1'b1}};
    dec.c = c_in;
    unique case (mode)
      2'b00: begin
        dec.v = i8;
        dec.r = irot;
        if (irot != '0)
          dec.c = i8[irot - sh_t'(1)];
      end
      2'b11: begin
        dec.v = W'(imm);
      end
      default: begin
        if (mode == 2'b01 && ty == 2'b11 && imm[11:7] == 5'd0) begin
          dec.v = {c_in, rm[W-1:1]};
          dec.c = rm[0];
        end else if (amt != 8'd0) begin
          unique case (ty)
            2'b00: begin
              // LSL k is a right-rotate by W-k with the low k bits cleared
              if (lt) begin
                dec.r = ni;
                dec.m = {W{1'b1}} << al;
                dec.c = rm[ni];
              end else begin
                dec.m = '0;
                dec.c = eq & rm[0];
              end
            end
            2'b01: begin
              if (lt) begin
                dec.r = al;
                dec.m = {W{1'b1}} >> al;
                dec.c = rm[ai];
              end else begin
                dec.m = '0;
                dec.c = eq & rm[W-1];
              end
            end
            2'b10: begin
              dec.f = rm[W-1];
              if (lt) begin
                dec.r = al;
                dec.m = {W{1'b1}} >> al;
                dec.c = rm[ai];
              end else begin
                dec.m = '0;
                dec.c = rm[W-1];
              end
            end
            2'b11: begin
              dec.r = al;
              dec.c = (al == '0) ? rm[W-1] : rm[ai];
            end
          endcase
        end
      end
    endcase
  end

  assign adv      = !vld_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  always_comb begin
    vld_d = (vld_q << 1) | STAGES'(in_valid);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      vld_q <= '0;
    else if (adv)
      vld_q <= vld_d;
  end

  bun_t sb [STAGES];
  assign sb[0] = dec;

  for (genvar s = 0; s < STAGES; s++) begin : g_st
    localparam int LO = s * LW / STAGES;
    localparam int HI = (s + 1) * LW / STAGES;
    bun_t d;

    always_comb begin
      d = sb[s];
      for (int l = 0; l < LW; l++) begin
        if (l >= LO && l < HI && d.r[l])
          d.v = (d.v >> (1 << l)) | (d.v << (W - (1 << l)));
      end
    end

    if (s < STAGES - 1) begin : g_mid
      bun_t q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          q <= '0;
        else if (adv)
          q <= d;
      end
      assign sb[s+1] = q;
    end else begin : g_last
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          n_q <= '0;
          c_q <= 1'b0;
        end else if (adv) begin
          n_q <= (d.v & d.m) | (~d.m & {W{d.f}});
          c_q <= d.c;
        end
      end
    end
  end

  assign out_valid = vld_q[STAGES-1];
  assign n         = n_q;
  assign c_out     = c_q;

endmodule

// File: tb/tb_shifter_operand_pipe.sv
// tb_shifter_operand_pipe: directed + randomized bench for the
// shifter operand pipe, W=32, STAGES=2, against a behavioural model.
module tb_shifter_operand_pipe;
  localparam int W  = 32;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  rm;
  logic [7:0]    rs_amt;
  logic [11:0]   imm;
  logic [1:0]    mode;
  logic          c_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  n;
  logic          c_out;

  always #5 clk = ~clk;

  shifter_operand_pipe #(
    .WIDTH (W),
    .STAGES(ST)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .rm       (rm),
    .rs_amt   (rs_amt),
    .imm      (imm),
    .mode     (mode),
    .c_in     (c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .n        (n),
    .c_out    (c_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] n;
    logic        c;
  } res_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int k);
    logic [63:0] t;
    t = {x, x} >> k;
    return t[31:0];
  endfunction

  function automatic res_t model(input logic [31:0] r, input logic [7:0] s,
                                 input logic [11:0] i, input logic [1:0] m,
                                 input logic c);
    int k;
    logic [31:0] nn;
    logic cc;
    logic [1:0] ty;
    ty = i[6:5];
    nn = r;
    cc = c;
    case (m)
      2'b00: begin
        k  = 2 * int'(i[11:8]);
        nn = rotr(32'(i[7:0]), k);
        cc = (k == 0) ? c : nn[31];
      end
      2'b01: begin
        k = int'(i[11:7]);
        case (ty)
          2'b00: if (k != 0) begin nn = r << k; cc = r[32-k]; end
          2'b01: begin
            if (k == 0) begin nn = 0; cc = r[31]; end
            else begin nn = r >> k; cc = r[k-1]; end
          end
          2'b10: begin
            if (k == 0) begin nn = {32{r[31]}}; cc = r[31]; end
            else begin nn = $signed(r) >>> k; cc = r[k-1]; end
          end
          default: begin
            if (k == 0) begin nn = {c, r[31:1]}; cc = r[0]; end
            else begin nn = rotr(r, k); cc = nn[31]; end
          end
        endcase
      end
      2'b10: begin
        k = int'(s);
        if (k != 0) begin
          case (ty)
            2'b00: begin
              if (k < 32) begin nn = r << k; cc = r[32-k]; end
              else if (k == 32) begin nn = 0; cc = r[0]; end
              else begin nn = 0; cc = 1'b0; end
            end
            2'b01: begin
              if (k < 32) begin nn = r >> k; cc = r[k-1]; end
              else if (k == 32) begin nn = 0; cc = r[31]; end
              else begin nn = 0; cc = 1'b0; end
            end
            2'b10: begin
              if (k < 32) begin nn = $signed(r) >>> k; cc = r[k-1]; end
              else begin nn = {32{r[31]}}; cc = r[31]; end
            end
            default: begin
              if (k % 32 == 0) begin nn = r; cc = r[31]; end
              else begin nn = rotr(r, k % 32); cc = nn[31]; end
            end
          endcase
        end
      end
      default: begin
        nn = 32'(i);
        cc = c;
      end
    endcase
    return '{n: nn, c: cc};
  endfunction

  res_t        sbq[$];
  int          pushed = 0;
  int          popped = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] last_n;
  logic        last_c;
  res_t        e;

  always @(negedge clk) begin
    if (reset) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_n", n, last_n);
        chk("hold_c", 32'(c_out), 32'(last_c));
        chk("hold_v", 32'(out_valid), 1);
      end
      if (in_valid && in_ready) begin
        sbq.push_back(model(rm, rs_amt, imm, mode, c_in));
        pushed++;
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          chk("sb_extra", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("sb_n", n, e.n);
          chk("sb_c", 32'(c_out), 32'(e.c));
          popped++;
        end
      end
      stall_prev = out_valid && !out_ready;
      last_n = n;
      last_c = c_out;
    end
  end

  task automatic dir(input string tag, input logic [31:0] r,
                     input logic [7:0] s, input logic [11:0] i,
                     input logic [1:0] m, input logic c,
                     input logic [31:0] en, input logic ec);
    int lat;
    in_valid = 1'b1;
    rm = r; rs_amt = s; imm = i; mode = m; c_in = c;
    chk({tag, "_rdy"}, 32'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, 2);
    chk({tag, "_n"}, n, en);
    chk({tag, "_c"}, 32'(c_out), 32'(ec));
    @(posedge clk); #1;
  endtask

  task automatic drive_txn(input logic [31:0] r, input logic [7:0] s,
                           input logic [11:0] i, input logic [1:0] m,
                           input logic c);
    int t;
    logic ok;
    t = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    rm = r; rs_amt = s; imm = i; mode = m; c_in = c;
    while (!ok && t < 100) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      t++;
    end
    if (!ok) chk("acc_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic rand_txn(output logic [31:0] r, output logic [7:0] s,
                          output logic [11:0] i, output logic [1:0] m,
                          output logic c);
    m = 2'($urandom);
    c = 1'($urandom);
    i = 12'($urandom);
    if ($urandom_range(0, 3) == 0) i[11:7] = 5'd0;
    case ($urandom_range(0, 3))
      0: r = 32'h8000_0001;
      1: r = 32'h0000_0003;
      default: r = $urandom;
    endcase
    case ($urandom_range(0, 5))
      0: s = 8'd0;
      1: s = 8'd32;
      2: s = 8'd33;
      3: s = 8'd31;
      4: s = 8'd64;
      default: s = 8'($urandom);
    endcase
  endtask

  logic [31:0] g_r;
  logic [7:0]  g_s;
  logic [11:0] g_i;
  logic [1:0]  g_m;
  logic        g_c;
  logic        done;
  int          p0;
  int          q0;
  int          w;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    rm = '0; rs_amt = '0; imm = '0; mode = '0; c_in = 1'b0;
    #1;
    chk("rst_v", 32'(out_valid), 0);
    chk("rst_n", n, 0);
    chk("rst_c", 32'(c_out), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_rdy", 32'(in_ready), 1);

    dir("rot4", 32'h0, 8'h0, 12'h4FF, 2'b00, 1'b0, 32'hFF00_0000, 1'b1);
    dir("rot0", 32'h0, 8'h0, 12'h0FF, 2'b00, 1'b1, 32'h0000_00FF, 1'b1);
    dir("lsr0", 32'h8000_0001, 8'h0, 12'h020, 2'b01, 1'b0, 32'h0, 1'b1);
    dir("asr0", 32'h8000_0001, 8'h0, 12'h040, 2'b01, 1'b0,
        32'hFFFF_FFFF, 1'b1);
    dir("rrx", 32'h3, 8'h0, 12'h060, 2'b01, 1'b1, 32'h8000_0001, 1'b1);
    dir("lsl32", 32'h1, 8'd32, 12'h000, 2'b10, 1'b0, 32'h0, 1'b1);
    dir("lsl33", 32'h1, 8'd33, 12'h000, 2'b10, 1'b0, 32'h0, 1'b0);
    dir("rs0", 32'h1, 8'd0, 12'h000, 2'b10, 1'b0, 32'h1, 1'b0);
    dir("ror32", 32'h8000_0000, 8'd32, 12'h060, 2'b10, 1'b0,
        32'h8000_0000, 1'b1);
    dir("ofs", 32'h0, 8'h0, 12'hABC, 2'b11, 1'b1, 32'h0000_0ABC, 1'b1);

    p0 = popped;
    fork
      begin
        for (int t = 0; t < 4; t++) begin
          rand_txn(g_r, g_s, g_i, g_m, g_c);
          drive_txn(g_r, g_s, g_i, g_m, g_c);
        end
      end
      begin
        @(posedge clk);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_vld", 32'(out_valid), 1);
          chk("bp_rdy", 32'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    w = 0;
    while (popped - p0 < 4 && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    chk("bp_count", popped - p0, 4);
    chk("bp_empty", 32'(sbq.size()), 0);

    p0 = popped;
    q0 = pushed;
    done = 1'b0;
    fork
      begin
        for (int t = 0; t < 300; t++) begin
          rand_txn(g_r, g_s, g_i, g_m, g_c);
          drive_txn(g_r, g_s, g_i, g_m, g_c);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    w = 0;
    while (sbq.size() != 0 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("rnd_drain", 32'(sbq.size()), 0);
    chk("rnd_count", popped - p0, pushed - q0);
    chk("rnd_total", pushed - q0, 300);

    in_valid = 1'b1;
    rm = 32'h0; rs_amt = 8'h0; imm = 12'h123; mode = 2'b11; c_in = 1'b0;
    @(posedge clk); #1;
    imm = 12'h456;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_v", 32'(out_valid), 1);
    reset = 1'b1;
    sbq.delete();
    #1;
    chk("mid_rst_v", 32'(out_valid), 0);
    chk("mid_rst_n", n, 0);
    chk("mid_rst_c", 32'(c_out), 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("post_rst_v", 32'(out_valid), 0);
    chk("post_rst_rdy", 32'(in_ready), 1);
    dir("after_rst", 32'hF000_000F, 8'd4, 12'h020, 2'b10, 1'b0,
        32'h0F00_0000, 1'b1);
    chk("final_empty", 32'(sbq.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
